// File: rtl/mem_seq.sv
// mem_seq: command sequencer for a single-port RAM. Accepts WRITE, READ,
// FILL and SCAN commands one at a time. Every RAM strobe and every read
// result is registered, so the RAM bus is glitch-free and rd_data/rd_addr
// hold their value between strobes.
module mem_seq #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [ADDR_W-1:0] cmd_len,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              mem_we,
  output logic              mem_oe,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, FILL, SCAN} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state;
  // Words still to be accessed after the current one; zero for single-word
  // commands so WRITE/FILL and READ/SCAN can share their state logic.
  logic [ADDR_W-1:0] remaining;

  // Single sequencer: accepts a command in IDLE, walks the RAM one word per
  // cycle, captures read data at the closing edge of each access and keeps
  // cmd_ready/busy registered alongside the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_addr   <= '0;
      mem_we    <= 1'b0;
      mem_oe    <= 1'b0;
      mem_add   <= '0;
      mem_in    <= '0;
    end else begin
      case (state)
        IDLE: begin
          rd_valid <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            mem_add   <= cmd_addr;
            case (cmd_op)
              2'b00: begin
                state     <= WRITE;
                mem_we    <= 1'b1;
                mem_in    <= cmd_data;
                remaining <= '0;
              end
              2'b01: begin
                state     <= READ;
                mem_oe    <= 1'b1;
                mem_in    <= '0;
                remaining <= '0;
              end
              2'b10: begin
                state     <= FILL;
                mem_we    <= 1'b1;
                mem_in    <= cmd_data;
                remaining <= cmd_len;
              end
              default: begin
                state     <= SCAN;
                mem_oe    <= 1'b1;
                mem_in    <= '0;
                remaining <= cmd_len;
              end
            endcase
          end else begin
            // Either truly idle or the last read strobe is being presented;
            // in both cases the next cycle can take a command.
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end

        WRITE, FILL: begin
          if (remaining == '0) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_add   <= '0;
            mem_in    <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            mem_add   <= mem_add + ADDR_ONE;
            remaining <= remaining - ADDR_ONE;
          end
        end

        READ, SCAN: begin
          rd_valid <= 1'b1;
          rd_data  <= mem_out;
          rd_addr  <= mem_add;
          if (remaining == '0) begin
            // The final strobe is still pending, so stay busy and not ready
            // for one more cycle.
            state     <= IDLE;
            mem_oe    <= 1'b0;
            mem_add   <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            mem_add   <= mem_add + ADDR_ONE;
            remaining <= remaining - ADDR_ONE;
          end
        end

        default: begin
          state     <= IDLE;
          remaining <= '0;
          cmd_ready <= 1'b0;
          busy      <= 1'b0;
          rd_valid  <= 1'b0;
          mem_we    <= 1'b0;
          mem_oe    <= 1'b0;
          mem_add   <= '0;
          mem_in    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: randomized and directed bench for mem_seq. The stimulus side
// pushes expected RAM writes and read strobes into queues; a negedge monitor
// pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_mem_seq;

  localparam int AW    = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [AW-1:0] cmd_len = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_addr;
  logic          busy;
  logic          mem_we;
  logic          mem_oe;
  logic [AW-1:0] mem_add;
  logic [DW-1:0] mem_in;
  logic [DW-1:0] mem_out;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t wr_q[$];
  exp_t rd_q[$];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int last_rd_data = 0;
  int last_rd_addr = 0;

  logic [DW-1:0] ram [DEPTH];
  int            model_mem [DEPTH];

  mem_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_addr   (rd_addr),
    .busy      (busy),
    .mem_we    (mem_we),
    .mem_oe    (mem_oe),
    .mem_add   (mem_add),
    .mem_in    (mem_in),
    .mem_out   (mem_out)
  );

  always #5 clk = ~clk;

  // Free-running cycle count used to time every expected bus event.
  always @(posedge clk) cycle <= cycle + 1;

  // The RAM the sequencer drives: asynchronous read, synchronous write.
  assign mem_out = mem_oe ? ram[mem_add] : '0;

  always @(posedge clk) begin
    if (mem_we) ram[mem_add] <= mem_in;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Reference model: applies the command to an abstract memory array and
  // lists the bus events it must produce, k being the acceptance edge.
  task automatic pushModel(input int op, input int addr, input int data,
                           input int len, input int k);
    int a;
    case (op)
      0: begin
        model_mem[addr] = data;
        wr_q.push_back('{addr, data, k});
      end
      1: rd_q.push_back('{addr, model_mem[addr], k + 1});
      2: for (int i = 0; i <= len; i++) begin
        a = (addr + i) % DEPTH;
        model_mem[a] = data;
        wr_q.push_back('{a, data, k + i});
      end
      default: for (int i = 0; i <= len; i++) begin
        a = (addr + i) % DEPTH;
        rd_q.push_back('{a, model_mem[a], k + 1 + i});
      end
    endcase
  endtask

  // Offers a command and waits (bounded) for acceptance. cmd_valid is left
  // high so a following call presents its command back-to-back.
  task automatic applyStimulus(input int op, input int addr, input int data,
                               input int len, output int k);
    int n;
    cmd_op    = 2'(op);
    cmd_addr  = AW'(addr);
    cmd_data  = DW'(data);
    cmd_len   = AW'(len);
    cmd_valid = 1'b1;
    n = 0;
    k = -1;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout op=%0d actual=not-ready expected=ready", op);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    k = cycle;
    pushModel(op, addr, data, len, k);
  endtask

  task automatic idleCycles(input int n);
    cmd_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDrain();
    int n;
    cmd_valid = 1'b0;
    n = 0;
    while ((wr_q.size() != 0 || rd_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", wr_q.size() + rd_q.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every write and read strobe, and checks
  // bus rules (exclusive enables, quiet idle bus, stable read outputs).
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_rd_data = 0;
      last_rd_addr = 0;
    end else begin
      checkOutput("we_oe_exclusive", 32'(mem_we & mem_oe), 0);
      if (!busy) checkOutput("idle_bus", 32'({mem_we, mem_oe, mem_add, mem_in}), 0);
      else checkOutput("ready_while_busy", 32'(cmd_ready), 0);
      if (mem_we) begin
        if (wr_q.size() == 0) checkOutput("unexpected_write", 32'(mem_we), 0);
        else begin
          e = wr_q.pop_front();
          checkOutput("wr_addr", 32'(mem_add), e.addr);
          checkOutput("wr_data", 32'(mem_in), e.data);
          checkOutput("wr_cycle", cycle, e.cyc);
        end
      end
      if (rd_valid) begin
        checkOutput("rd_busy", 32'(busy), 1);
        if (rd_q.size() == 0) checkOutput("unexpected_rd_valid", 32'(rd_valid), 0);
        else begin
          e = rd_q.pop_front();
          checkOutput("rd_addr", 32'(rd_addr), e.addr);
          checkOutput("rd_data", 32'(rd_data), e.data);
          checkOutput("rd_cycle", cycle, e.cyc);
          last_rd_data = e.data;
          last_rd_addr = e.addr;
        end
      end else begin
        checkOutput("rd_hold", 32'({rd_addr, rd_data}), 32'((last_rd_addr << DW) | last_rd_data));
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rd_valid"}, 32'(rd_valid), 0);
    checkOutput({tag, "_rd_data"}, 32'(rd_data), 0);
    checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_mem_en"}, 32'({mem_we, mem_oe}), 0);
    checkOutput({tag, "_mem_add"}, 32'(mem_add), 0);
    checkOutput({tag, "_mem_in"}, 32'(mem_in), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int k2;
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = '0;
      model_mem[i] = 0;
    end

    // Power-on reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ready_after_reset", 32'(cmd_ready), 1);

    // WRITE 3 <- A, then READ 3
    applyStimulus(0, 3, 4'hA, 0, k);
    applyStimulus(1, 3, 0, 0, k);
    waitDrain();

    // FILL 14 len 3 with data 5, second command held valid throughout
    applyStimulus(2, 14, 5, 3, k);
    applyStimulus(0, 7, 9, 0, k2);
    checkOutput("no_early_accept", 32'(k2 >= k + 5), 1);
    waitDrain();

    // Distinct words everywhere, then a full-range SCAN
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, i, (i * 7 + 3) % DEPTH, 0, k);
    applyStimulus(3, 0, 0, DEPTH - 1, k);
    waitDrain();

    // Random command mix
    for (int t = 0; t < 40; t++) begin
      applyStimulus($urandom_range(0, 3), $urandom_range(0, DEPTH - 1),
                    $urandom_range(0, (1 << DW) - 1), $urandom_range(0, DEPTH - 1), k);
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3));
    end
    waitDrain();

    // Asynchronous reset in the middle of a SCAN, at word 5
    applyStimulus(3, 0, 0, DEPTH - 1, k);
    cmd_valid = 1'b0;
    n = 0;
    while (!(rd_valid === 1'b1 && rd_addr === AW'(5)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scan_word5_reached", 32'(n < 100), 1);
    #1;
    rst = 1'b1;
    #1;
    checkAllZero("mid_scan_reset");
    rd_q.delete();
    wr_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ready_after_mid_reset", 32'(cmd_ready), 1);
    idleCycles(20);

    // Sequencer still works after the aborted burst
    applyStimulus(1, 3, 0, 0, k);
    applyStimulus(3, 14, 0, 3, k);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_seq.md
MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 4, RAM word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high in the same cycle as cmd_valid.
REQ-007 SHALL have port cmd_op  input  2  opcode: 00 WRITE, 01 READ, 10 FILL, 11 SCAN.
REQ-008 SHALL have port cmd_addr  input  ADDR_W  start address.
REQ-009 SHALL have port cmd_data  input  DATA_W  write/fill word.
REQ-010 SHALL have port cmd_len  input  ADDR_W  burst word count minus one; ignored for WRITE and READ.
REQ-011 SHALL have port rd_valid  output  1  one-cycle strobe marking valid rd_data and rd_addr.
REQ-012 SHALL have port rd_data  output  DATA_W  captured read word.
REQ-013 SHALL have port rd_addr  output  ADDR_W  address of rd_data.
REQ-014 SHALL have port busy  output  1  high while a command executes or a read result is pending.
REQ-015 SHALL have ports mem_we, mem_oe  output  1 each  RAM write and output enables.
REQ-016 SHALL have ports mem_add  output  ADDR_W and mem_in  output  DATA_W  RAM address and write data.
REQ-017 SHALL have port mem_out  input  DATA_W  RAM read data, valid combinationally while mem_oe is high.

Function
REQ-018 SHALL implement FSM states IDLE, WRITE, READ, FILL, SCAN.
REQ-019 SHALL drive cmd_ready high only in IDLE with no read strobe pending.
REQ-020 SHALL, on acceptance (cmd_valid and cmd_ready), latch op/addr/data/len and enter the opcode's state on the next edge.
REQ-021 SHALL in WRITE assert mem_we=1, mem_oe=0, mem_add=latched addr, mem_in=latched data for exactly one cycle, then return to IDLE.
REQ-022 SHALL in READ assert mem_oe=1, mem_we=0, mem_add=latched addr for one cycle, capture mem_out at that cycle's closing edge, and pulse rd_valid in the following cycle.
REQ-023 SHALL give a READ a latency of 2 cycles from the acceptance edge to the rd_valid cycle.
REQ-024 SHALL in FILL write latched data to addresses addr, addr+1, ... for len+1 consecutive cycles, one word per cycle, then return to IDLE.
REQ-025 SHALL in SCAN read addresses addr .. addr+len, one per cycle, with rd_valid asserted on the len+1 consecutive cycles that each follow an access.
REQ-026 SHALL increment addresses modulo 2^ADDR_W (wrap 15 -> 0 at the default width).
REQ-027 SHALL, when len = 2^ADDR_W-1, access every address exactly once.
REQ-028 SHALL never assert mem_we and mem_oe in the same cycle.
REQ-029 SHALL drive mem_we=0, mem_oe=0, mem_add=0, mem_in=0 in IDLE.
REQ-030 SHALL ignore cmd_valid while cmd_ready is low; no command is queued.
REQ-031 SHALL hold rd_data and rd_addr stable between strobes.
REQ-032 SHALL assert busy in any non-IDLE state and in the cycle rd_valid is high.

Reset
REQ-033 SHALL on rst force IDLE immediately, independent of clk, and clear all outputs to 0 except cmd_ready.
REQ-034 SHALL drive cmd_ready to 1 one cycle after rst deasserts.
REQ-035 SHALL, when rst asserts during a FILL or SCAN, abort the burst with no further mem_we or rd_valid, and not resume it after release.

Verification
REQ-036 SHALL be verified by: WRITE addr 3 data A, then READ addr 3 -> mem_we one cycle with mem_add=3, mem_in=A; rd_valid 2 cycles after READ acceptance with rd_data=A, rd_addr=3.
REQ-037 SHALL be verified by: FILL addr 14 len 3 data 5 -> mem_we on 4 cycles with mem_add 14, 15, 0, 1; busy high for those 4 cycles.
REQ-038 SHALL be verified by: SCAN addr 0 len 15 after distinct writes -> 16 rd_valid strobes, rd_addr 0..15 in order, data matching the writes.
REQ-039 SHALL be verified by: cmd_valid held high during a FILL -> cmd_ready low and no second command accepted until the FILL completes.
REQ-040 SHALL be verified by: rst pulsed mid-SCAN at word 5, between clock edges -> all outputs 0 immediately, no rd_valid afterwards, cmd_ready 1 one cycle after release.
REQ-041 SHALL be verified by: checker over every cycle -> never mem_we and mem_oe high together.
